// File: rtl/dsp_share_arbiter_pkg.sv
// Shared DSP-bus constants, FSM state type and a helper that packs one DSP input word.
package dsp_share_arbiter_pkg;

  localparam int DSP_IN_W  = 92;
  localparam int DSP_OUT_W = 48;
  localparam logic [7:0] DSP_NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GUARD
  } state_t;

  // Flat layout seen by the slice: {opmode, A, B, C}
  function automatic logic [DSP_IN_W-1:0] dsp_word(input logic [7:0] opmode,
                                                   input logic [17:0] a,
                                                   input logic [17:0] b,
                                                   input logic [47:0] c);
    return {opmode, a, b, c};
  endfunction

endpackage

// File: rtl/dsp_share_arbiter_if.sv
// Requester-side and slice-side buses of the shared stereo DSP pair.
interface dsp_share_arbiter_if
  import dsp_share_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IN_W  = DSP_IN_W,
  parameter int OUT_W = DSP_OUT_W
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       gnt;
  logic [NREQ*IN_W-1:0]  dsp_ins_flat_l_req;
  logic [NREQ*IN_W-1:0]  dsp_ins_flat_r_req;
  logic [NREQ*OUT_W-1:0] dsp_outs_flat_l_req;
  logic [NREQ*OUT_W-1:0] dsp_outs_flat_r_req;
  logic [IN_W-1:0]       dsp_ins_flat_l;
  logic [IN_W-1:0]       dsp_ins_flat_r;
  logic [OUT_W-1:0]      dsp_outs_flat_l;
  logic [OUT_W-1:0]      dsp_outs_flat_r;
  logic                  busy;
  logic                  hold_err;

  // master: engines plus the slice pair; slave: the arbiter
  modport master (
    output req, dsp_ins_flat_l_req, dsp_ins_flat_r_req, dsp_outs_flat_l, dsp_outs_flat_r,
    input  gnt, dsp_outs_flat_l_req, dsp_outs_flat_r_req, dsp_ins_flat_l, dsp_ins_flat_r,
           busy, hold_err
  );

  modport slave (
    input  req, dsp_ins_flat_l_req, dsp_ins_flat_r_req, dsp_outs_flat_l, dsp_outs_flat_r,
    output gnt, dsp_outs_flat_l_req, dsp_outs_flat_r_req, dsp_ins_flat_l, dsp_ins_flat_r,
           busy, hold_err
  );
endinterface

// File: rtl/dsp_share_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit after 'last', wrapping.
module dsp_share_arbiter_rr_pick #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    sum    = '0;
    k      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = {1'b0, last} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      k = sum[IW-1:0];
      if (!valid && req[k]) begin
        valid     = 1'b1;
        idx       = k;
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_share_arbiter.sv
// Round-robin time-sharing of one stereo DSP48A1 pair among NREQ engines,
// with a guard gap between owners and a hold watchdog.
//
//   state    | meaning
//   ST_IDLE  | no owner, arbitrate as soon as any req is set
//   ST_GRANT | one owner drives the slices; hold counter runs
//   ST_GUARD | forced zero-input gap, arbitrate on its last cycle
module dsp_share_arbiter
  import dsp_share_arbiter_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int IN_W         = DSP_IN_W,
  parameter int OUT_W        = DSP_OUT_W,
  parameter int GUARD_CYCLES = 1,
  parameter int HOLD_MAX     = 255
) (
  input  logic               clk,
  input  logic               reset,
  dsp_share_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  state_t            state, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     last_q, last_d;
  logic [HW-1:0]     hold_cnt, hold_d;
  logic [GW-1:0]     guard_cnt, guard_d;
  logic              err_q, err_d;
  logic [NREQ-1:0]   pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic              owner_req;

  dsp_share_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      gnt_q     <= '0;
      last_q    <= IW'(NREQ - 1);
      hold_cnt  <= '0;
      guard_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      hold_cnt  <= hold_d;
      guard_cnt <= guard_d;
      err_q     <= err_d;
    end
  end

  assign owner_req = |(bus.req & gnt_q);

  always_comb begin
    state_d = state;
    gnt_d   = gnt_q;
    last_d  = last_q;
    hold_d  = hold_cnt;
    guard_d = guard_cnt;
    err_d   = err_q;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          gnt_d   = pick_onehot;
          last_d  = pick_idx;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        // Release and watchdog eviction share the same exit path into the guard gap
        if (!owner_req || hold_cnt == HW'(HOLD_MAX - 1)) begin
          state_d = ST_GUARD;
          gnt_d   = '0;
          hold_d  = '0;
          guard_d = '0;
          if (owner_req) err_d = 1'b1;
        end else begin
          hold_d = hold_cnt + HW'(1);
        end
      end
      ST_GUARD: begin
        if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
          if (pick_valid) begin
            state_d = ST_GRANT;
            gnt_d   = pick_onehot;
            last_d  = pick_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          guard_d = guard_cnt + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  logic [IN_W-1:0]       ins_l, ins_r;
  logic [NREQ*OUT_W-1:0] outs_l, outs_r;

  // gnt_q is one-hot or zero, so a plain priority select is a true mux
  always_comb begin
    ins_l  = {DSP_NOP, {(IN_W-8){1'b0}}};
    ins_r  = {DSP_NOP, {(IN_W-8){1'b0}}};
    outs_l = '0;
    outs_r = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_q[k]) begin
        ins_l = bus.dsp_ins_flat_l_req[k*IN_W +: IN_W];
        ins_r = bus.dsp_ins_flat_r_req[k*IN_W +: IN_W];
        outs_l[k*OUT_W +: OUT_W] = bus.dsp_outs_flat_l;
        outs_r[k*OUT_W +: OUT_W] = bus.dsp_outs_flat_r;
      end
    end
  end

  assign bus.gnt                 = gnt_q;
  assign bus.dsp_ins_flat_l      = ins_l;
  assign bus.dsp_ins_flat_r      = ins_r;
  assign bus.dsp_outs_flat_l_req = outs_l;
  assign bus.dsp_outs_flat_r_req = outs_r;
  assign bus.busy                = (state != ST_IDLE);
  assign bus.hold_err            = err_q;

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Directed bench for dsp_share_arbiter: reset, single grant, round-robin,
// watchdog, async reset and a 34-MAC burst.
module tb_dsp_share_arbiter;
  import dsp_share_arbiter_pkg::*;

  localparam int NREQ         = 4;
  localparam int IN_W         = DSP_IN_W;
  localparam int OUT_W        = DSP_OUT_W;
  localparam int GUARD_CYCLES = 1;
  localparam int HOLD_MAX     = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dsp_share_arbiter_if #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  dsp_share_arbiter #(
    .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W),
    .GUARD_CYCLES(GUARD_CYCLES), .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [IN_W-1:0] word_l(input int k);
    return dsp_word(8'(16 + k), 18'(256 + k), 18'(512 + k), 48'(4096 + k));
  endfunction

  function automatic logic [IN_W-1:0] word_r(input int k);
    return dsp_word(8'(32 + k), 18'(768 + k), 18'(1024 + k), 48'(8192 + k));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_all;
    for (int k = 0; k < NREQ; k++) begin
      bus.dsp_ins_flat_l_req[k*IN_W +: IN_W] = word_l(k);
      bus.dsp_ins_flat_r_req[k*IN_W +: IN_W] = word_r(k);
    end
  endtask

  task automatic test_reset;
    bus.req = '0;
    bus.dsp_ins_flat_l_req = '0;
    bus.dsp_ins_flat_r_req = '0;
    bus.dsp_outs_flat_l = '0;
    bus.dsp_outs_flat_r = '0;
    reset = 1'b1;
    #2;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.dsp_ins_flat_l !== '0) begin errors++; $display("FAIL reset_ins_l: got %h want 0", bus.dsp_ins_flat_l); end
    checks++; if (bus.hold_err !== 1'b0) begin errors++; $display("FAIL reset_hold_err: got %b want 0", bus.hold_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b want 0000", bus.gnt); end
  endtask

  task automatic test_single;
    logic [NREQ*OUT_W-1:0] exp_l, exp_r;
    load_all();
    bus.dsp_outs_flat_l = 48'h0000_1234_5678;
    bus.dsp_outs_flat_r = 48'h0000_9abc_def0;
    exp_l = '0;
    exp_r = '0;
    exp_l[2*OUT_W +: OUT_W] = 48'h0000_1234_5678;
    exp_r[2*OUT_W +: OUT_W] = 48'h0000_9abc_def0;
    bus.req = 4'b0100;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
    checks++; if (bus.dsp_ins_flat_l !== word_l(2)) begin errors++; $display("FAIL single_ins_l: got %h want %h", bus.dsp_ins_flat_l, word_l(2)); end
    checks++; if (bus.dsp_ins_flat_r !== word_r(2)) begin errors++; $display("FAIL single_ins_r: got %h want %h", bus.dsp_ins_flat_r, word_r(2)); end
    checks++; if (bus.dsp_outs_flat_l_req !== exp_l) begin errors++; $display("FAIL single_outs_l: got %h want %h", bus.dsp_outs_flat_l_req, exp_l); end
    checks++; if (bus.dsp_outs_flat_r_req !== exp_r) begin errors++; $display("FAIL single_outs_r: got %h want %h", bus.dsp_outs_flat_r_req, exp_r); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    repeat (9) tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt_held: got %b want 0100", bus.gnt); end
    bus.req = '0;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_release_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.dsp_ins_flat_l !== '0) begin errors++; $display("FAIL single_guard_ins: got %h want 0", bus.dsp_ins_flat_l); end
    checks++; if (bus.dsp_outs_flat_l_req !== '0) begin errors++; $display("FAIL single_guard_outs: got %h want 0", bus.dsp_outs_flat_l_req); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_guard_busy: got %b want 1", bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_round_robin;
    int exp_owner;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    load_all();
    exp_owner = 0;
    bus.req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 5; c++) begin
        checks++; if (bus.gnt !== (4'b0001 << exp_owner)) begin errors++; $display("FAIL rr_gnt grant %0d cycle %0d: got %b want %b", n, c, bus.gnt, 4'b0001 << exp_owner); end
        checks++; if (bus.dsp_ins_flat_l !== word_l(exp_owner)) begin errors++; $display("FAIL rr_ins_l grant %0d cycle %0d: got %h want %h", n, c, bus.dsp_ins_flat_l, word_l(exp_owner)); end
        if (c < 4) tick();
      end
      if (n == 4) bus.req = '0;
      else bus.req[exp_owner] = 1'b0;
      tick();
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rr_guard_gnt after %0d: got %b want 0000", n, bus.gnt); end
      checks++; if (bus.dsp_ins_flat_l !== '0) begin errors++; $display("FAIL rr_guard_ins after %0d: got %h want 0", n, bus.dsp_ins_flat_l); end
      if (n < 4) bus.req[exp_owner] = 1'b1;
      tick();
      exp_owner = (exp_owner + 1) % NREQ;
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_end_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_watchdog;
    int n;
    n = 0;
    bus.req = 4'b1010;
    tick();
    while (bus.gnt === 4'b0010 && n < 300) begin
      n++;
      if (n == 254) begin
        checks++; if (bus.hold_err !== 1'b0) begin errors++; $display("FAIL wd_err_early: got %b want 0", bus.hold_err); end
      end
      tick();
    end
    checks++; if (n != HOLD_MAX) begin errors++; $display("FAIL wd_hold_cycles: got %0d want %0d", n, HOLD_MAX); end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL wd_evict_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.hold_err !== 1'b1) begin errors++; $display("FAIL wd_err_set: got %b want 1", bus.hold_err); end
    tick();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL wd_next_owner: got %b want 1000", bus.gnt); end
    tick();
    bus.req[3] = 1'b0;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL wd_guard2_gnt: got %b want 0000", bus.gnt); end
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL wd_regrant: got %b want 0010", bus.gnt); end
    checks++; if (bus.hold_err !== 1'b1) begin errors++; $display("FAIL wd_err_sticky: got %b want 1", bus.hold_err); end
    bus.req = '0;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wd_end_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_async_reset;
    load_all();
    bus.dsp_outs_flat_r = 48'h0000_00ab_cdef;
    bus.req = 4'b0100;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL ar_gnt: got %b want 0100", bus.gnt); end
    repeat (6) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL ar_gnt_drop: got %b want 0000", bus.gnt); end
    checks++; if (bus.dsp_ins_flat_r !== '0) begin errors++; $display("FAIL ar_ins_r: got %h want 0", bus.dsp_ins_flat_r); end
    checks++; if (bus.dsp_outs_flat_r_req !== '0) begin errors++; $display("FAIL ar_outs_r: got %h want 0", bus.dsp_outs_flat_r_req); end
    checks++; if (bus.hold_err !== 1'b0) begin errors++; $display("FAIL ar_err_clear: got %b want 0", bus.hold_err); end
    #2;
    reset = 1'b0;
    bus.req = 4'b0101;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL ar_first_winner: got %b want 0001", bus.gnt); end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_burst;
    logic [IN_W-1:0]  w;
    logic [OUT_W-1:0] p_model, got;
    logic [17:0]      a_val, b_val;
    a_val = 18'h0A263;
    b_val = 18'h10000;
    p_model = '0;
    load_all();
    bus.dsp_ins_flat_l_req[0 +: IN_W] = '0;
    bus.dsp_outs_flat_l = '0;
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL burst_gnt: got %b want 0001", bus.gnt); end
    for (int i = 0; i < 34; i++) begin
      w = dsp_word(8'h05, a_val, b_val, 48'(i));
      bus.dsp_ins_flat_l_req[0 +: IN_W] = w;
      #1;
      checks++; if (bus.dsp_ins_flat_l !== w) begin errors++; $display("FAIL burst_mac %0d: got %h want %h", i, bus.dsp_ins_flat_l, w); end
      p_model = p_model + 48'(a_val) * 48'(b_val);
      tick();
    end
    bus.dsp_ins_flat_l_req[0 +: IN_W] = '0;
    tick();
    tick();
    bus.dsp_outs_flat_l = p_model;
    #1;
    got = bus.dsp_outs_flat_l_req[0 +: OUT_W];
    checks++; if (got[33:16] !== p_model[33:16]) begin errors++; $display("FAIL burst_p: got %h want %h", got[33:16], p_model[33:16]); end
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL burst_still_granted: got %b want 0001", bus.gnt); end
    checks++; if (bus.dsp_outs_flat_l_req[OUT_W +: 3*OUT_W] !== '0) begin errors++; $display("FAIL burst_foreign_p: got %h want 0", bus.dsp_outs_flat_l_req[OUT_W +: 3*OUT_W]); end
    bus.req = '0;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL burst_end_busy: got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_async_reset();
    test_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
